// File: rtl/usart_buffered_controller.sv
// USART with 2-flop RX synchroniser, RX FIFO (first-word fall-through), valid/ready host port and runtime loopback echo.
// Optional even parity on TX and RX is compiled in when USART_PARITY_EN is defined.
module usart_buffered_controller #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BIT   = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx,
  output logic                          tx,
  input  logic                          loopback,
  input  logic [DATA_BIT-1:0]           tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic [DATA_BIT-1:0]           rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          overrun,
  output logic                          frame_err,
  output logic                          parity_err
);

  localparam int CPB = CLK_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(CPB + 1);
  localparam int BW  = $clog2(DATA_BIT);
  localparam int AW  = $clog2(FIFO_DEPTH);
`ifdef USART_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  state_t              tx_state, tx_state_nx, rx_state, rx_state_nx;
  logic                running;
  logic [CW-1:0]       tx_cnt, rx_cnt;
  logic [BW-1:0]       tx_idx, rx_idx;
  logic [DATA_BIT-1:0] tx_shift, rx_shift, tx_src;
  logic                tx_par, tx_idle, tx_bit_end, tx_load;
  logic                rx_s1, rx_s2, rx_sample, rx_stop_hit, rx_par_bit, rx_par_bad, push_p;
  logic [DATA_BIT-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         count;
  logic                fifo_nempty, fifo_full, fifo_pop, push_ok;

  // running keeps tx_ready low for as long as reset is held
  assign tx_idle     = (tx_state == S_IDLE);
  assign tx_bit_end  = (tx_cnt == CW'(CPB - 1));
  assign tx_ready    = running & tx_idle & ~loopback;
  assign tx_load     = loopback ? (running & tx_idle & fifo_nempty) : (tx_valid & tx_ready);
  assign tx_src      = loopback ? rx_data : tx_data;
  assign fifo_nempty = (count != '0);
  assign fifo_full   = (count == (AW+1)'(FIFO_DEPTH));
  assign fifo_pop    = fifo_nempty & (loopback ? (running & tx_idle) : rx_ready);
  assign push_ok     = push_p & (~fifo_full | fifo_pop);
  assign rx_data     = fifo_nempty ? mem[rd_ptr] : '0;
  assign rx_valid    = fifo_nempty & ~loopback;
  assign rx_count    = count;

  always_comb begin
    tx_state_nx = tx_state;
    case (tx_state)
      S_IDLE:  if (tx_load) tx_state_nx = S_START;
      S_START: if (tx_bit_end) tx_state_nx = S_DATA;
      S_DATA:  if (tx_bit_end && tx_idx == BW'(DATA_BIT - 1)) tx_state_nx = PAR_EN ? S_PAR : S_STOP;
      S_PAR:   if (tx_bit_end) tx_state_nx = S_STOP;
      S_STOP:  if (tx_bit_end) tx_state_nx = S_IDLE;
      default: tx_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    tx = 1'b1;
    case (tx_state)
      S_START: tx = 1'b0;
      S_DATA:  tx = tx_shift[0];
      S_PAR:   tx = tx_par;
      default: tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      running  <= 1'b0;
    end else begin
      running  <= 1'b1;
      tx_state <= tx_state_nx;
      if (tx_idle || tx_bit_end) tx_cnt <= '0;
      else                       tx_cnt <= tx_cnt + 1'b1;
      if (tx_load)                              tx_idx <= '0;
      else if (tx_state == S_DATA && tx_bit_end) tx_idx <= tx_idx + 1'b1;
    end
  end

  // TX byte and parity are latched at acceptance so the source may change mid-frame
  always_ff @(posedge clk) begin
    if (tx_load) begin
      tx_shift <= tx_src;
      tx_par   <= ^tx_src;
    end else if (tx_state == S_DATA && tx_bit_end) begin
      tx_shift <= tx_shift >> 1;
    end
  end

  // rx_cnt reads k in cycle D+k, so the start mid-sample lands on CPB/2 and later ones every CPB
  assign rx_sample   = (rx_state != S_IDLE) &&
                       ((rx_state == S_START) ? (rx_cnt == CW'(CPB / 2)) : (rx_cnt == CW'(CPB)));
  assign rx_stop_hit = (rx_state == S_STOP) && rx_sample;
  assign rx_par_bad  = PAR_EN & ((^rx_shift) ^ rx_par_bit);

  always_comb begin
    rx_state_nx = rx_state;
    case (rx_state)
      S_IDLE:  if (!rx_s2) rx_state_nx = S_START;
      S_START: if (rx_sample) rx_state_nx = rx_s2 ? S_IDLE : S_DATA;
      S_DATA:  if (rx_sample && rx_idx == BW'(DATA_BIT - 1)) rx_state_nx = PAR_EN ? S_PAR : S_STOP;
      S_PAR:   if (rx_sample) rx_state_nx = S_STOP;
      S_STOP:  if (rx_sample) rx_state_nx = S_IDLE;
      default: rx_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_state  <= S_IDLE;
      rx_cnt    <= '0;
      rx_idx    <= '0;
      push_p    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_s1    <= rx;
      rx_s2    <= rx_s1;
      rx_state <= rx_state_nx;
      if (rx_state == S_IDLE || rx_sample) rx_cnt <= CW'(1);
      else                                 rx_cnt <= rx_cnt + 1'b1;
      if (rx_state == S_IDLE)                    rx_idx <= '0;
      else if (rx_state == S_DATA && rx_sample)  rx_idx <= rx_idx + 1'b1;
      push_p    <= rx_stop_hit & rx_s2 & ~rx_par_bad;
      frame_err <= rx_stop_hit & ~rx_s2;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_state == S_DATA && rx_sample) rx_shift   <= {rx_s2, rx_shift[DATA_BIT-1:1]};
    if (rx_state == S_PAR && rx_sample)  rx_par_bit <= rx_s2;
  end

`ifdef USART_PARITY_EN
  always_ff @(posedge clk) begin
    if (!reset) parity_err <= 1'b0;
    else        parity_err <= rx_stop_hit & rx_par_bad;
  end
`else
  assign parity_err = 1'b0;
`endif

  // FIFO stage: a push into a full FIFO survives only if the head is popped in the same cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (push_ok)  wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, fifo_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      overrun <= push_p & fifo_full & ~fifo_pop;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= rx_shift;
  end

endmodule

// File: tb/tb_usart_buffered_controller.sv
// Scoreboard bench for usart_buffered_controller: 16 clk/bit, 8 data bits, 4-entry FIFO, no parity.
module tb_usart_buffered_controller;
  localparam int CPB = 16;

  logic       clk = 1'b0, reset = 1'b0, rx = 1'b1, loopback = 1'b0;
  logic       tx_valid = 1'b0, rx_ready = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx, tx_ready, rx_valid, overrun, frame_err, parity_err;
  logic [7:0] rx_data;
  logic [2:0] rx_count;

  int tests = 0, fails = 0;
  int cyc = 0;
  int ovr_n = 0, fe_n = 0, pe_n = 0, lbv_n = 0, last_inc_cyc = 0;
  logic [2:0] prev_cnt = 3'd0;

  logic [7:0] sb_q[$];
  logic [7:0] tx_exp_q[$];
  logic [7:0] dec_q[$];
  int         dec_start_q[$];
  logic [7:0] dec_byte;
  int         dec_st;

  usart_buffered_controller #(
    .CLK_FREQ(16), .BAUD_RATE(1), .DATA_BIT(8), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .rx(rx), .tx(tx), .loopback(loopback),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_count(rx_count),
    .overrun(overrun), .frame_err(frame_err), .parity_err(parity_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (overrun === 1'b1)    ovr_n <= ovr_n + 1;
    if (frame_err === 1'b1)  fe_n  <= fe_n + 1;
    if (parity_err === 1'b1) pe_n  <= pe_n + 1;
    if (loopback && rx_valid === 1'b1) lbv_n <= lbv_n + 1;
    if (rx_count > prev_cnt) last_inc_cyc <= cyc;
    prev_cnt <= rx_count;
  end

  // Line decoder on tx: samples mid-bit, records byte and start cycle
  initial begin
    forever begin
      @(negedge clk);
      if (tx === 1'b0 && reset === 1'b1) begin
        dec_st = cyc;
        repeat (CPB/2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          dec_byte[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        dec_q.push_back(dec_byte);
        dec_start_q.push_back(dec_st);
      end
    end
  end

  task automatic rx_send(input logic [7:0] b, input logic stop_bit, output int c0);
    c0 = cyc;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic host_send(input logic [7:0] b);
    int n = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      tests++; fails++;
      $display("FAIL host_send_timeout: tx_ready=%b required 1", tx_ready);
    end
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = ~b;
  endtask

  task automatic pop_one(input string name);
    logic [7:0] exp;
    tests++;
    if (rx_valid !== 1'b1 || sb_q.size() == 0) begin
      fails++;
      $display("FAIL %s_valid: rx_valid=%b queued=%0d required 1", name, rx_valid, sb_q.size());
    end else begin
      exp = sb_q.pop_front();
      tests++;
      if (rx_data !== exp) begin
        fails++;
        $display("FAIL %s_data: got %h required %h", name, rx_data, exp);
      end
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    tests++; if (tx !== 1'b1)         begin fails++; $display("FAIL rst_tx: got %b required 1", tx); end
    tests++; if (tx_ready !== 1'b0)   begin fails++; $display("FAIL rst_tx_ready: got %b required 0", tx_ready); end
    tests++; if (rx_valid !== 1'b0)   begin fails++; $display("FAIL rst_rx_valid: got %b required 0", rx_valid); end
    tests++; if (rx_count !== 3'd0)   begin fails++; $display("FAIL rst_rx_count: got %0d required 0", rx_count); end
    tests++; if (rx_data !== 8'h00)   begin fails++; $display("FAIL rst_rx_data: got %h required 00", rx_data); end
    tests++; if ({overrun, frame_err, parity_err} !== 3'b000)
      begin fails++; $display("FAIL rst_pulses: got %b required 000", {overrun, frame_err, parity_err}); end
    reset = 1'b1;
    @(negedge clk);
    tests++; if (tx_ready !== 1'b1)   begin fails++; $display("FAIL rst_release_ready: got %b required 1", tx_ready); end
  endtask

  task automatic test_host_tx;
    logic [7:0] b = 8'hA5;
    logic       expb, got;
    bit         ok;
    int         rdy_low = 0;
    tx_exp_q.push_back(b);
    host_send(b);
    for (int s = 0; s < 10; s++) begin
      expb = (s == 0) ? 1'b0 : (s == 9) ? 1'b1 : b[s-1];
      ok = 1'b1; got = expb;
      for (int c = 0; c < CPB; c++) begin
        if (tx !== expb) begin ok = 1'b0; got = tx; end
        if (tx_ready === 1'b0) rdy_low++;
        @(negedge clk);
      end
      tests++;
      if (!ok) begin fails++; $display("FAIL tx_slot%0d: got %b required %b", s, got, expb); end
    end
    tests++; if (rdy_low != 160)    begin fails++; $display("FAIL tx_ready_low_cycles: got %0d required 160", rdy_low); end
    tests++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL tx_ready_after: got %b required 1", tx_ready); end
    tests++; if (tx !== 1'b1)       begin fails++; $display("FAIL tx_idle_after: got %b required 1", tx); end
    tests++;
    if (dec_q.size() == 0) begin fails++; $display("FAIL tx_decode: no frame decoded, required %h", tx_exp_q[0]); end
    else begin
      dec_byte = dec_q.pop_front();
      void'(dec_start_q.pop_front());
      if (dec_byte !== tx_exp_q[0]) begin fails++; $display("FAIL tx_decode: got %h required %h", dec_byte, tx_exp_q[0]); end
      void'(tx_exp_q.pop_front());
    end
  endtask

  task automatic test_back_to_back;
    int n = 0;
    dec_q.delete(); dec_start_q.delete(); tx_exp_q.delete();
    tx_exp_q.push_back(8'hC3); tx_exp_q.push_back(8'h3C);
    host_send(8'hC3);
    host_send(8'h3C);
    while (dec_q.size() < 2 && n < 400) begin @(negedge clk); n++; end
    tests++;
    if (dec_q.size() < 2) begin fails++; $display("FAIL b2b_frames: got %0d frames required 2", dec_q.size()); end
    else begin
      for (int i = 0; i < 2; i++) begin
        dec_byte = dec_q[i];
        tests++;
        if (dec_byte !== tx_exp_q[i]) begin fails++; $display("FAIL b2b_byte%0d: got %h required %h", i, dec_byte, tx_exp_q[i]); end
      end
      if (dec_start_q[1] - dec_start_q[0] != 161)
        begin fails++; $display("FAIL b2b_gap: got %0d required 161", dec_start_q[1] - dec_start_q[0]); end
    end
    dec_q.delete(); dec_start_q.delete(); tx_exp_q.delete();
  endtask

  task automatic test_host_rx;
    int c0, c1;
    sb_q.push_back(8'h3C);
    rx_send(8'h3C, 1'b1, c0);
    tests++; if (last_inc_cyc != c0 + 156) begin fails++; $display("FAIL rx_write_time: got %0d required %0d", last_inc_cyc, c0 + 156); end
    sb_q.push_back(8'h81);
    rx_send(8'h81, 1'b1, c1);
    tests++; if (rx_count !== 3'd2) begin fails++; $display("FAIL rx_count2: got %0d required 2", rx_count); end
    pop_one("rx_first");
    pop_one("rx_second");
    tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL rx_empty_valid: got %b required 0", rx_valid); end
    tests++; if (rx_count !== 3'd0) begin fails++; $display("FAIL rx_empty_count: got %0d required 0", rx_count); end
  endtask

  task automatic test_overflow;
    int c0, ovr0;
    logic [7:0] frames [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    ovr0 = ovr_n;
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back(frames[i]);
      rx_send(frames[i], 1'b1, c0);
    end
    tests++; if (rx_count !== 3'd4) begin fails++; $display("FAIL ovf_count4: got %0d required 4", rx_count); end
    tests++; if (ovr_n != ovr0)     begin fails++; $display("FAIL ovf_early: got %0d pulses required 0", ovr_n - ovr0); end
    rx_send(frames[4], 1'b1, c0);
    repeat (4) @(negedge clk);
    tests++; if (ovr_n - ovr0 != 1) begin fails++; $display("FAIL ovf_pulse: got %0d pulses required 1", ovr_n - ovr0); end
    tests++; if (rx_count !== 3'd4) begin fails++; $display("FAIL ovf_count_full: got %0d required 4", rx_count); end
    for (int i = 0; i < 4; i++) pop_one("ovf_pop");
    tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL ovf_drained: got %b required 0", rx_valid); end
  endtask

  task automatic test_errors;
    int c0, fe0, pe0, ovr0;
    logic [2:0] cnt0;
    fe0 = fe_n; pe0 = pe_n; ovr0 = ovr_n; cnt0 = rx_count;
    rx_send(8'h5A, 1'b0, c0);
    repeat (20) @(negedge clk);
    tests++; if (fe_n - fe0 != 1)   begin fails++; $display("FAIL err_frame_pulse: got %0d required 1", fe_n - fe0); end
    tests++; if (rx_count !== cnt0) begin fails++; $display("FAIL err_frame_count: got %0d required %0d", rx_count, cnt0); end
    fe0 = fe_n;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    tests++; if (fe_n != fe0 || ovr_n != ovr0 || pe_n != pe0)
      begin fails++; $display("FAIL glitch_pulse: got fe=%0d ovr=%0d pe=%0d required 0", fe_n - fe0, ovr_n - ovr0, pe_n - pe0); end
    tests++; if (rx_count !== cnt0) begin fails++; $display("FAIL glitch_count: got %0d required %0d", rx_count, cnt0); end
    sb_q.push_back(8'h96);
    rx_send(8'h96, 1'b1, c0);
    pop_one("after_err");
  endtask

  task automatic test_loopback;
    int c0, lbv0, n = 0;
    loopback = 1'b1;
    dec_q.delete(); dec_start_q.delete(); tx_exp_q.delete();
    @(negedge clk);
    tests++; if (tx_ready !== 1'b0) begin fails++; $display("FAIL lb_tx_ready: got %b required 0", tx_ready); end
    lbv0 = lbv_n;
    tx_exp_q.push_back(8'h55);
    rx_send(8'h55, 1'b1, c0);
    while (dec_q.size() == 0 && n < 400) begin @(negedge clk); n++; end
    tests++;
    if (dec_q.size() == 0) begin fails++; $display("FAIL lb_echo: no frame decoded, required %h", tx_exp_q[0]); end
    else begin
      dec_byte = dec_q.pop_front();
      dec_st   = dec_start_q.pop_front();
      if (dec_byte !== tx_exp_q[0]) begin fails++; $display("FAIL lb_echo: got %h required %h", dec_byte, tx_exp_q[0]); end
      void'(tx_exp_q.pop_front());
      tests++;
      if (dec_st != c0 + 157) begin fails++; $display("FAIL lb_latency: got start %0d required %0d", dec_st, c0 + 157); end
    end
    tests++; if (lbv_n != lbv0)     begin fails++; $display("FAIL lb_rx_valid: got %0d cycles high required 0", lbv_n - lbv0); end
    tests++; if (rx_count !== 3'd0) begin fails++; $display("FAIL lb_count: got %0d required 0", rx_count); end
    loopback = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset_mid_tx;
    int c0;
    rx_send(8'h77, 1'b1, c0);
    tests++; if (rx_count !== 3'd1) begin fails++; $display("FAIL rmt_pre_count: got %0d required 1", rx_count); end
    host_send(8'h00);
    repeat (49) @(negedge clk);
    tests++; if (tx !== 1'b0) begin fails++; $display("FAIL rmt_pre_tx: got %b required 0", tx); end
    reset = 1'b0;
    @(negedge clk);
    tests++; if (tx !== 1'b1)       begin fails++; $display("FAIL rmt_tx: got %b required 1", tx); end
    tests++; if (tx_ready !== 1'b0) begin fails++; $display("FAIL rmt_tx_ready: got %b required 0", tx_ready); end
    tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL rmt_rx_valid: got %b required 0", rx_valid); end
    tests++; if (rx_data !== 8'h00) begin fails++; $display("FAIL rmt_rx_data: got %h required 00", rx_data); end
    reset = 1'b1;
    @(negedge clk);
    tests++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL rmt_release_ready: got %b required 1", tx_ready); end
    tests++; if (rx_count !== 3'd0) begin fails++; $display("FAIL rmt_release_count: got %0d required 0", rx_count); end
    tests++; if (tx !== 1'b1)       begin fails++; $display("FAIL rmt_release_tx: got %b required 1", tx); end
  endtask

  initial begin
    test_reset();
    test_host_tx();
    test_back_to_back();
    test_host_rx();
    test_overflow();
    test_errors();
    test_loopback();
    test_reset_mid_tx();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
